// File: rtl/jt51_logsin_dec_if.sv
// jt51_logsin_dec_if: bus between the operator phase source, the log-sine
// decode stage and its external phase ROM.
//   phase_in/vld_in : operator phase and its valid (source -> stage)
//   rom_addr        : quarter-wave ROM row address (stage -> ROM)
//   rom_ph          : registered ROM row (ROM -> stage)
//   logsin/sign     : saturated log-attenuation and waveform sign
//   vld_out         : logsin/sign valid
// The slave modport is the decode stage; the master modport is its environment.
interface jt51_logsin_dec_if #(
  parameter int OUTW = 10,
  parameter int ROMW = 46
);
  logic [9:0]      phase_in;
  logic            vld_in;
  logic [4:0]      rom_addr;
  logic [ROMW-1:0] rom_ph;
  logic [OUTW-1:0] logsin;
  logic            sign;
  logic            vld_out;

  modport slave (
    input  phase_in, vld_in, rom_ph,
    output rom_addr, logsin, sign, vld_out
  );

  modport master (
    output phase_in, vld_in, rom_ph,
    input  rom_addr, logsin, sign, vld_out
  );
endinterface

// File: rtl/jt51_logsin_dec.sv
// jt51_logsin_dec: operator-path stage around the 32x46 log-sine phase ROM.
// Folds a 10-bit phase to a quarter wave, addresses the ROM, then decodes the
// returned row into a saturated log-attenuation plus sign.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   cen   : clock enable, every register advances only when high
//   bus   : jt51_logsin_dec_if.slave (phase in, ROM addr/row, logsin out)
// Latency is three cen cycles, one sample accepted per cen cycle.
module jt51_logsin_dec #(
  parameter int OUTW = 10,
  parameter int ROMW = 46
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cen,
  jt51_logsin_dec_if.slave bus
);

  localparam int STAGES = 3;
  localparam logic [11:0] SATV = 12'((1 << OUTW) - 1);

  // The row layout below is hard-wired to 46 bits.
  if (ROMW != 46) begin : g_romw_chk
    $error("jt51_logsin_dec: ROMW must be 46");
  end

  logic [7:0]        q, q1;
  logic              sg1, sg2;
  logic [1:0]        sel2;
  logic              lo2;
  logic [STAGES:1]   vld_pipe;
  logic [OUTW-1:0]   logsin_r;
  logic              sign_r;

  logic [9:0]        base;
  logic [3:0][8:0]   fld;
  logic [11:0]       sum;

  // Quarter-wave fold: the mirrored quarter reads the table backwards.
  always_comb q = bus.phase_in[8] ? ~bus.phase_in[7:0] : bus.phase_in[7:0];

  // S1: fold register; S2: side-band aligned with the ROM's own register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1       <= '0;
      sg1      <= 1'b0;
      sel2     <= '0;
      lo2      <= 1'b0;
      sg2      <= 1'b0;
      vld_pipe <= '0;
    end else if (cen) begin
      q1       <= q;
      sg1      <= bus.phase_in[9];
      sel2     <= q1[7:6];
      lo2      <= q1[0];
      sg2      <= sg1;
      vld_pipe <= {vld_pipe[STAGES-1:1], bus.vld_in};
    end
  end

  assign bus.rom_addr = q1[5:1];

  // Row layout: base in [45:36], then four 9-bit offsets, field 0 highest.
  assign base = bus.rom_ph[45:36];
  for (genvar k = 0; k < 4; k++) begin : g_fld
    assign fld[k] = bus.rom_ph[35-9*k -: 9];
  end

  // Full-width sum so the saturation compare sees any carry out of OUTW bits.
  always_comb sum = {2'b00, base} + {3'b000, fld[sel2]} + {11'd0, lo2};

  // S3: saturate and register outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      logsin_r <= '0;
      sign_r   <= 1'b0;
    end else if (cen) begin
      logsin_r <= (sum > SATV) ? SATV[OUTW-1:0] : sum[OUTW-1:0];
      sign_r   <= sg2;
    end
  end

  assign bus.logsin  = logsin_r;
  assign bus.sign    = sign_r;
  assign bus.vld_out = vld_pipe[STAGES];

endmodule

// File: tb/tb_jt51_logsin_dec.sv
// Directed bench for jt51_logsin_dec with a behavioural 32x46 ROM.
module tb_jt51_logsin_dec;

  logic clk, rst_n, cen;
  int   tests = 0;
  int   fails = 0;

  jt51_logsin_dec_if bus ();

  jt51_logsin_dec u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cen   (cen),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ROM contents: row0 from the datasheet example, row1/row2/row31 chosen for
  // hand-checked sums, all other rows distinct so addressing faults show up.
  logic [45:0] rom [32];
  initial begin
    for (int r = 0; r < 32; r++) rom[r] = {10'd500, 36'd0};
    rom[0]  = {10'd96,   9'd290, 9'd66, 9'd341, 9'd82};
    rom[1]  = {10'd200,  9'd1,   9'd2,  9'd3,   9'd4};
    rom[2]  = {10'd1000, 9'd22,  9'd24, 9'd0,   9'd0};
    rom[31] = {10'd923,  9'd10,  9'd20, 9'd30,  9'd423};
  end

  initial bus.rom_ph = '0;
  always @(posedge clk) if (cen) bus.rom_ph <= rom[bus.rom_addr];

  typedef struct {
    logic       v;
    logic [9:0] l;
    logic       s;
  } exp_t;

  exp_t       expq [$];
  logic       hv, hs;
  logic [9:0] hl;
  logic [4:0] ha;

  function automatic logic [4:0] addr_of(input logic [9:0] ph);
    logic [7:0] qq;
    qq = ph[8] ? ~ph[7:0] : ph[7:0];
    return qq[5:1];
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic preload();
    exp_t e;
    e.v = 1'b0; e.l = '0; e.s = 1'b0;
    expq.delete();
    expq.push_back(e);
    expq.push_back(e);
    hv = 1'b0; hl = '0; hs = 1'b0; ha = '0;
  endtask

  // One clk edge; with c=1 the sample (ph,v) is accepted with expected
  // result (el,es) three cen cycles later; with c=0 everything must hold.
  task automatic cyc(input logic c, input logic [9:0] ph, input logic v,
                     input logic [9:0] el, input logic es);
    exp_t e, o;
    cen = c; bus.phase_in = ph; bus.vld_in = v;
    @(posedge clk); #1;
    if (c) begin
      e.v = v; e.l = el; e.s = es;
      expq.push_back(e);
      o  = expq.pop_front();
      hv = o.v; hl = o.l; hs = o.s;
      ha = addr_of(ph);
    end
    chk("vld_out", 16'(bus.vld_out), 16'(hv));
    chk("rom_addr", 16'(bus.rom_addr), 16'(ha));
    if (hv) begin
      chk("logsin", 16'(bus.logsin), 16'(hl));
      chk("sign", 16'(bus.sign), 16'(hs));
    end
  endtask

  // Async reset with a live random stream; outputs must be cleared at once.
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    #1;
    chk("rst_vld_out", 16'(bus.vld_out), 16'd0);
    chk("rst_logsin", 16'(bus.logsin), 16'd0);
    for (int i = 0; i < n; i++) begin
      cen = 1'b1; bus.phase_in = 10'($urandom); bus.vld_in = 1'b1;
      @(posedge clk); #1;
      chk("rst_rom_addr", 16'(bus.rom_addr), 16'd0);
      chk("rst_logsin", 16'(bus.logsin), 16'd0);
      chk("rst_sign", 16'(bus.sign), 16'd0);
      chk("rst_vld_out", 16'(bus.vld_out), 16'd0);
    end
    rst_n = 1'b1;
    preload();
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; cen = 1'b0;
    bus.phase_in = '0; bus.vld_in = 1'b0;
    @(posedge clk); #1;
    do_reset(4);

    // basic decode, mirror and sign
    cyc(1, 10'h000, 1, 10'd386,  0);
    cyc(1, 10'h081, 1, 10'd438,  0);
    cyc(1, 10'h1FF, 1, 10'd386,  0);
    cyc(1, 10'h3FF, 1, 10'd386,  1);
    cyc(1, 10'h0FF, 1, 10'd1023, 0);
    cyc(1, 10'h0C0, 1, 10'd178,  0);
    cyc(1, 10'h100, 1, 10'd1023, 0);
    cyc(1, 10'h2FF, 1, 10'd1023, 1);
    cyc(1, 10'h03F, 1, 10'd934,  0);
    cyc(1, 10'h07E, 1, 10'd943,  0);
    cyc(1, 10'h002, 1, 10'd201,  0);
    cyc(1, 10'h1FD, 1, 10'd201,  0);
    // saturation edge: 1022, exactly 1023, 1024
    cyc(1, 10'h004, 1, 10'd1022, 0);
    cyc(1, 10'h005, 1, 10'd1023, 0);
    cyc(1, 10'h044, 1, 10'd1023, 0);

    // valid pattern with gaps 1,0,1,1
    cyc(1, 10'h081, 1, 10'd438, 0);
    cyc(1, 10'h0C0, 0, 10'd0,   0);
    cyc(1, 10'h000, 1, 10'd386, 0);
    cyc(1, 10'h0C0, 1, 10'd178, 0);

    // wrap 0x3FF -> 0x000
    cyc(1, 10'h3FF, 1, 10'd386, 1);
    cyc(1, 10'h000, 1, 10'd386, 0);

    // cen gating: garbage on the inputs while cen=0 must be ignored
    cyc(1, 10'h000, 1, 10'd386,  0);
    cyc(0, 10'h0FF, 1, 10'd0,    0);
    cyc(0, 10'h2AA, 0, 10'd0,    0);
    cyc(1, 10'h081, 1, 10'd438,  0);
    cyc(0, 10'h3C3, 1, 10'd0,    0);
    cyc(1, 10'h0FF, 1, 10'd1023, 0);
    cyc(0, 10'h155, 1, 10'd0,    0);
    cyc(1, 10'h000, 0, 10'd0,    0);
    cyc(0, 10'h0C0, 1, 10'd0,    0);
    cyc(1, 10'h000, 0, 10'd0,    0);
    cyc(0, 10'h081, 1, 10'd0,    0);
    cyc(1, 10'h000, 0, 10'd0,    0);
    cyc(0, 10'h000, 0, 10'd0,    0);

    // reset mid-stream discards in-flight samples
    cyc(1, 10'h081, 1, 10'd438,  0);
    cyc(1, 10'h0FF, 1, 10'd1023, 0);
    do_reset(2);
    cyc(1, 10'h3FF, 0, 10'd0,    0);
    cyc(1, 10'h0C0, 1, 10'd178,  0);
    cyc(1, 10'h000, 0, 10'd0,    0);
    cyc(1, 10'h000, 0, 10'd0,    0);
    cyc(1, 10'h000, 0, 10'd0,    0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
